// File: rtl/mem_axi_resp_stub.sv
// AXI4 memory responder backed by an on-chip RAM, standing in for the EMIF end of the memory AXI-MM link.
// One write burst and one read burst may be in flight at once, each handled by its own FSM.
module mem_axi_resp_stub #(
  parameter int ID_WIDTH   = 9,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awqos,

  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,

  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,

  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arqos,

  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The *_RST states hold every ready low until the first edge after reset is released.
  typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_RST, R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  w_state_t              w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [LEN_WIDTH-1:0]  w_cnt;
  logic                  w_incr;
  logic                  w_err;

  r_state_t              r_state;
  r_state_t              r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_incr;
  logic [DATA_WIDTH-1:0] r_data_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic r_hs;
  logic w_done;
  logic unused_inputs;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign w_done = wlast || (w_cnt == '0);

  assign unused_inputs = ^{awaddr, awsize, awlock, awcache, awprot, awqos,
                           araddr, arsize, arlock, arcache, arprot, arqos};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_RST;
      r_state <= R_RST;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_RST:  w_next = W_IDLE;
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_done) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // The burst is in error unless it is INCR and wlast lands exactly on the final counted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id   <= '0;
      w_idx  <= '0;
      w_cnt  <= '0;
      w_incr <= 1'b0;
      w_err  <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id   <= awid;
        w_idx  <= awaddr[OFF+DEPTH_LOG2-1:OFF];
        w_cnt  <= awlen;
        w_incr <= (awburst == BURST_INCR);
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt - 1'b1;
        if (w_done) w_err <= !w_incr || (wlast != (w_cnt == '0));
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_RST:  r_next = R_IDLE;
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_next = (r_cnt == '0) ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_incr <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id   <= arid;
        r_idx  <= araddr[OFF+DEPTH_LOG2-1:OFF];
        r_cnt  <= arlen;
        r_incr <= (arburst == BURST_INCR);
      end
      if (r_hs) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Non-INCR bursts never touch the RAM, so a rejected FIXED/WRAP burst leaves contents intact.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_hs && w_incr && wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (r_state == R_FETCH) r_data_q <= mem[r_idx];
  end

  assign bid   = bvalid ? w_id : '0;
  assign bresp = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign rid   = rvalid ? r_id : '0;
  assign rdata = rvalid ? r_data_q : '0;
  assign rresp = (rvalid && !r_incr) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && (r_cnt == '0);

endmodule
